// File: rtl/apb_initiator_pkg.sv
// Shared types and defaults for the APB initiator.
package apb_initiator_pkg;

  localparam int unsigned DEF_ADDR_W = 13;
  localparam int unsigned DEF_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } state_e;

  typedef struct packed {
    logic [DEF_DATA_W-1:0] rdata;
    logic                  err;
    logic                  timeout;
  } rsp_t;

endpackage

// File: rtl/apb_initiator.sv
// APB requester: accepts one valid/ready command, runs an APB SETUP/ACCESS
// transfer with an optional wait-state timeout, and returns a registered
// response on a valid/ready stream. One transfer outstanding at a time.
module apb_initiator
  import apb_initiator_pkg::*;
#(
  parameter int unsigned APB_ADDR_WIDTH = DEF_ADDR_W,
  parameter int unsigned APB_DATA_WIDTH = DEF_DATA_W,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_valid_i,
  output logic                      req_ready_o,
  input  logic [APB_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [APB_DATA_WIDTH-1:0] req_wdata_i,
  input  logic                      req_write_i,
  output logic                      rsp_valid_o,
  input  logic                      rsp_ready_i,
  output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
  output logic                      rsp_err_o,
  output logic                      rsp_timeout_o,
  output logic [APB_ADDR_WIDTH-1:0] apb_paddr_o,
  output logic [APB_DATA_WIDTH-1:0] apb_pwdata_o,
  output logic                      apb_pwrite_o,
  output logic                      apb_psel_o,
  output logic                      apb_penable_o,
  input  logic [APB_DATA_WIDTH-1:0] apb_prdata_i,
  input  logic                      apb_pready_i,
  input  logic                      apb_pslverr_i
);

  localparam int unsigned     CNT_W    = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam bit              TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e                    state_q, state_d;
  logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                      write_q, write_d;
  logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                      err_q, err_d;
  logic                      tmo_q, tmo_d;
  logic [CNT_W-1:0]          wait_q, wait_d;

  // State, capture, response and wait-counter registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tmo_q   <= 1'b0;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state logic: request capture, APB phase sequencing, response capture.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    wait_d  = wait_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid_i) begin
          addr_d  = req_addr_i;
          write_d = req_write_i;
          wdata_d = req_write_i ? req_wdata_i : '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        wait_d  = '0;
        state_d = ACCESS;
      end
      ACCESS: begin
        if (apb_pready_i) begin
          rdata_d = write_q ? '0 : apb_prdata_i;
          err_d   = apb_pslverr_i;
          tmo_d   = 1'b0;
          state_d = RESP;
        end else begin
          // Saturate rather than wrap so a disabled timeout cannot alias.
          if (wait_q != '1) wait_d = wait_q + 1'b1;
          if (TMO_EN && (wait_q == CNT_LAST)) begin
            rdata_d = '0;
            err_d   = 1'b1;
            tmo_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        if (rsp_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready_o   = (state_q == IDLE) && !rst_i;
  assign apb_psel_o    = (state_q == SETUP) || (state_q == ACCESS);
  assign apb_penable_o = (state_q == ACCESS);
  assign apb_paddr_o   = addr_q;
  assign apb_pwdata_o  = wdata_q;
  assign apb_pwrite_o  = write_q;
  assign rsp_valid_o   = (state_q == RESP);
  assign rsp_rdata_o   = rdata_q;
  assign rsp_err_o     = err_q;
  assign rsp_timeout_o = tmo_q;

endmodule

// File: tb/tb_apb_initiator.sv
// Self-checking bench for apb_initiator: transaction-level reference model,
// per-cycle compare process, directed cases and randomized traffic.
module tb_apb_initiator;

  localparam int unsigned AW  = 13;
  localparam int unsigned DW  = 32;
  localparam int unsigned TMO = 16;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [AW-1:0] req_addr_i = '0;
  logic [DW-1:0] req_wdata_i = '0;
  logic          req_write_i = 1'b0;
  logic          rsp_valid_o;
  logic          rsp_ready_i = 1'b1;
  logic [DW-1:0] rsp_rdata_o;
  logic          rsp_err_o;
  logic          rsp_timeout_o;
  logic [AW-1:0] apb_paddr_o;
  logic [DW-1:0] apb_pwdata_o;
  logic          apb_pwrite_o;
  logic          apb_psel_o;
  logic          apb_penable_o;
  logic [DW-1:0] apb_prdata_i = '0;
  logic          apb_pready_i = 1'b0;
  logic          apb_pslverr_i = 1'b0;

  apb_initiator #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_write_i(req_write_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
    .rsp_rdata_o(rsp_rdata_o), .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
    .apb_paddr_o(apb_paddr_o), .apb_pwdata_o(apb_pwdata_o), .apb_pwrite_o(apb_pwrite_o),
    .apb_psel_o(apb_psel_o), .apb_penable_o(apb_penable_o),
    .apb_prdata_i(apb_prdata_i), .apb_pready_i(apb_pready_i), .apb_pslverr_i(apb_pslverr_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-request completer behaviour supplied alongside the request.
  int            cur_w = 0;
  logic [DW-1:0] cur_prdata = '0;
  logic          cur_slverr = 1'b0;

  // Transaction-level model. cyc counts cycles since acceptance:
  // 1 = setup, 2..len+1 = access, len+2 = response pending.
  bit            m_init = 0;
  bit            m_busy = 0;
  int            m_cyc = 0;
  int            m_len = 0;
  int            m_w = 0;
  logic [DW-1:0] m_prdata = '0;
  logic          m_slverr = 1'b0;
  logic [AW-1:0] m_addr = '0;
  logic [DW-1:0] m_wdata = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic          m_to = 1'b0;
  bit            m_tmo_tx = 0;

  always @(posedge clk) begin
    if (rst_i) begin
      m_init = 1; m_busy = 0; m_cyc = 0;
      m_addr = '0; m_wdata = '0; m_write = 1'b0;
      m_rdata = '0; m_err = 1'b0; m_to = 1'b0;
    end else if (!m_busy) begin
      if (req_valid_i) begin
        m_busy   = 1;
        m_cyc    = 1;
        m_addr   = req_addr_i;
        m_write  = req_write_i;
        m_wdata  = req_write_i ? req_wdata_i : '0;
        m_w      = cur_w;
        m_prdata = cur_prdata;
        m_slverr = cur_slverr;
        m_tmo_tx = (TMO != 0) && (cur_w >= int'(TMO));
        m_len    = m_tmo_tx ? int'(TMO) : cur_w + 1;
      end
    end else if (m_cyc <= m_len + 1) begin
      m_cyc++;
      if (m_cyc == m_len + 2) begin
        if (m_tmo_tx) begin
          m_rdata = '0; m_err = 1'b1; m_to = 1'b1;
        end else begin
          m_rdata = m_write ? '0 : m_prdata;
          m_err = m_slverr; m_to = 1'b0;
        end
      end
    end else if (rsp_ready_i) begin
      m_busy = 0;
    end
  end

  // Completer: raises pready on access cycle w+1 of the current transfer.
  always @(posedge clk) begin
    #1;
    if (m_busy && m_cyc >= 2 && m_cyc <= m_len + 1) begin
      apb_pready_i  = (m_cyc - 2 == m_w);
      apb_prdata_i  = (m_cyc - 2 == m_w) ? m_prdata : DW'($urandom);
      apb_pslverr_i = (m_cyc - 2 == m_w) ? m_slverr : 1'($urandom_range(0, 1));
    end else begin
      apb_pready_i  = 1'($urandom_range(0, 1));
      apb_prdata_i  = DW'($urandom);
      apb_pslverr_i = 1'($urandom_range(0, 1));
    end
  end

  // Response-ready driver: 0 = tied high, 1 = held low, 2 = random.
  int rr_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rr_mode)
      0:       rsp_ready_i = 1'b1;
      1:       rsp_ready_i = 1'b0;
      default: rsp_ready_i = 1'($urandom_range(0, 1));
    endcase
  end

  // Compare every cycle against the model.
  always @(negedge clk) begin
    if (m_init) begin
      chk("req_ready", req_ready_o, !m_busy && !rst_i);
      chk("psel", apb_psel_o, m_busy && m_cyc <= m_len + 1);
      chk("penable", apb_penable_o, m_busy && m_cyc >= 2 && m_cyc <= m_len + 1);
      chk("rsp_valid", rsp_valid_o, m_busy && m_cyc == m_len + 2);
      chk("paddr", apb_paddr_o, m_addr);
      chk("pwdata", apb_pwdata_o, m_wdata);
      chk("pwrite", apb_pwrite_o, m_write);
      chk("rsp_rdata", rsp_rdata_o, m_rdata);
      chk("rsp_err", rsp_err_o, m_err);
      chk("rsp_timeout", rsp_timeout_o, m_to);
    end
  end

  task automatic send(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic wr,
                      input int w, input logic [DW-1:0] prd, input logic se);
    bit acc;
    acc = 0;
    req_addr_i = a; req_wdata_i = d; req_write_i = wr;
    cur_w = w; cur_prdata = prd; cur_slverr = se;
    req_valid_i = 1'b1;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = req_ready_o;
      @(posedge clk);
      #1;
    end
    if (!acc) begin
      n_checks++; n_errors++;
      $display("FAIL req_accept: request not accepted within 200 cycles");
    end
    req_valid_i = 1'b0;
    req_addr_i  = AW'($urandom);
    req_wdata_i = DW'($urandom);
    req_write_i = 1'($urandom_range(0, 1));
  endtask

  task automatic wait_rsp(output int ps, output int pe, output logic [DW-1:0] rd,
                          output logic er, output logic to);
    bit got;
    got = 0; ps = 0; pe = 0; rd = '0; er = 1'b0; to = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin
        got = 1; rd = rsp_rdata_o; er = rsp_err_o; to = rsp_timeout_o;
      end else begin
        ps += int'(apb_psel_o);
        pe += int'(apb_penable_o);
      end
    end
    if (!got) begin
      n_checks++; n_errors++;
      $display("FAIL rsp_wait: no response within 100 cycles");
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int ps, pe, ps2, pe2;
    logic [DW-1:0] rd, rd2;
    logic er, to, er2, to2;
    int w;

    rst_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;

    // Zero-wait write.
    send(13'h0010, 32'h0000_4141, 1'b1, 0, 32'h0, 1'b0);
    wait_rsp(ps, pe, rd, er, to);
    chk("wr_psel_cycles", ps, 2);
    chk("wr_penable_cycles", pe, 1);
    chk("wr_rdata", rd, 0);
    chk("wr_err", er, 0);
    chk("wr_timeout", to, 0);

    // Read with three wait states.
    send(13'h0960, 32'h0, 1'b0, 3, 32'hDEAD_BEEF, 1'b0);
    wait_rsp(ps, pe, rd, er, to);
    chk("rd3_penable_cycles", pe, 4);
    chk("rd3_rdata", rd, 32'hDEAD_BEEF);
    chk("rd3_err", er, 0);

    // Slave error alongside pready.
    send(13'h0008, 32'h0, 1'b0, 0, 32'h1234_5678, 1'b1);
    wait_rsp(ps, pe, rd, er, to);
    chk("slverr_err", er, 1);
    chk("slverr_timeout", to, 0);
    chk("slverr_rdata", rd, 32'h1234_5678);

    // pready never comes: abort after 16 access cycles.
    send(13'h0100, 32'h0, 1'b0, 40, 32'hCAFE_F00D, 1'b0);
    wait_rsp(ps, pe, rd, er, to);
    chk("tmo_penable_cycles", pe, 16);
    chk("tmo_err", er, 1);
    chk("tmo_timeout", to, 1);
    chk("tmo_rdata", rd, 0);

    // pready on the 16th access cycle wins over the timeout.
    send(13'h0104, 32'h0, 1'b0, 15, 32'h0BAD_CAFE, 1'b0);
    wait_rsp(ps, pe, rd, er, to);
    chk("last_penable_cycles", pe, 16);
    chk("last_timeout", to, 0);
    chk("last_err", er, 0);
    chk("last_rdata", rd, 32'h0BAD_CAFE);

    // Back-pressure with a second request queued behind the response.
    rr_mode = 1;
    send(13'h0200, 32'hA5A5_0001, 1'b1, 1, 32'h0, 1'b0);
    fork
      begin
        wait_rsp(ps, pe, rd, er, to);
        for (int i = 0; i < 5; i++) begin
          chk("bp_rsp_valid_held", rsp_valid_o, 1);
          chk("bp_req_ready_low", req_ready_o, 0);
          @(negedge clk);
        end
        rr_mode = 0;
      end
      send(13'h0204, 32'h0, 1'b0, 2, 32'h7777_1234, 1'b0);
    join
    wait_rsp(ps2, pe2, rd2, er2, to2);
    chk("bp2_rdata", rd2, 32'h7777_1234);

    // Reset while in ACCESS: request dropped, no response.
    send(13'h0AAA, 32'h0, 1'b0, 10, 32'h1111_2222, 1'b0);
    @(posedge clk);
    #1 rst_i = 1'b1;
    @(posedge clk);
    #1 rst_i = 1'b0;
    @(negedge clk);
    chk("rst_psel", apb_psel_o, 0);
    chk("rst_penable", apb_penable_o, 0);
    chk("rst_req_ready", req_ready_o, 1);
    for (int i = 0; i < 5; i++) begin
      chk("rst_no_stale_rsp", rsp_valid_o, 0);
      @(negedge clk);
    end
    @(posedge clk);
    #1;

    // Randomized traffic with random response back-pressure.
    rr_mode = 2;
    for (int t = 0; t < 150; t++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      w = ($urandom_range(0, 7) == 0) ? int'($urandom_range(14, 20)) : int'($urandom_range(0, 4));
      send(AW'($urandom), DW'($urandom), 1'($urandom_range(0, 1)), w,
           DW'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    rr_mode = 0;
    for (int i = 0; i < 100 && m_busy; i++) begin
      @(posedge clk);
      #1;
    end
    if (m_busy) begin
      n_checks++; n_errors++;
      $display("FAIL drain: final transfer did not complete");
    end
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
